// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, FSM state type and helpers for the fetch stage
package if_pkg;

  localparam int          PC_W          = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0100_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] RESET_NPC_DEF = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } if_state_e;

  // Control-transfer targets are always word aligned; the low two bits are dropped.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with load enable and squash
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   load_i             capture a new entry on this edge
//   squash_i           when loading, replace the instruction by NOP and mark invalid
//   instr_i, pc_i      fetched instruction word and its address
//   instr_o, pc_o      registered instruction and address
//   valid_o            registered entry is a real, unsquashed instruction
module if_id_register
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_i,
  input  logic            squash_i,
  input  logic [PC_W-1:0] instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o
);

  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load_i) begin
      // A squashed slot still records the PC it occupied.
      pc_d    = pc_i;
      instr_d = squash_i ? NOP_INSTR : instr_i;
      valid_d = ~squash_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC/nPC delayed control transfer
//
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   le                       load enable: 1 advances the pipeline, 0 stalls
//   branch_taken, target_addr  taken control transfer from ID and its target
//   annul                    squash the instruction fetched this cycle
//   imem_data / imem_addr    asynchronous instruction memory read port
//   npc_out                  current nPC
//   if_id_instr/pc/valid     IF/ID register contents
//   instr_count              count of valid instructions delivered to IF/ID
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] RESET_NPC = RESET_NPC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            le,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] target_addr,
  input  logic            annul,
  input  logic [PC_W-1:0] imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] npc_out,
  output logic [PC_W-1:0] if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic [15:0]     instr_count
);

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            advance;

  // BOOT spends one cycle without fetching; both FETCH and STALL advance when le=1.
  assign advance = le && (state_q != ST_BOOT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = le ? ST_FETCH : ST_BOOT;
      ST_FETCH: state_d = le ? ST_FETCH : ST_STALL;
      ST_STALL: state_d = le ? ST_FETCH : ST_STALL;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    cnt_d = cnt_q;
    if (advance) begin
      pc_d  = npc_q;
      // nPC+4 wraps naturally at the 32-bit boundary.
      npc_d = branch_taken ? align_word(target_addr) : npc_q + 32'd4;
      if (!annul) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .resetn   (reset),
    .load_i   (advance),
    .squash_i (annul),
    .instr_i  (imem_data),
    .pc_i     (pc_q),
    .instr_o  (if_id_instr),
    .pc_o     (if_id_pc),
    .valid_o  (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign npc_out     = npc_q;
  assign instr_count = cnt_q;

endmodule
